regfile_initiator: RTL and testbench

- Initiator side of the RiSC-16 register-file port. It accepts read/write requests from the core pipeline and drives the register file's chip-select, write-enable, address and data lines.
- It compensates for the file's registered (1-cycle) read latency and for its read-old-on-write behaviour with a bypass path.
- It also provides a debug dump sequencer that reads out r0..r7 in order.

---
 rtl/regfile_initiator_if.sv | 46 ++++
 rtl/regfile_initiator.sv | 128 ++++++++++++
 tb/tb_regfile_initiator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_initiator_if.sv
// Bundle of the core-request, response, debug-dump and register-file lines of
// the RiSC-16 register-file initiator; master is the initiator, slave the far side.
interface regfile_initiator_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_src1;
    logic [AW-1:0] req_src2;
    logic          req_wen;
    logic [AW-1:0] req_tgt;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_src1_data;
    logic [DW-1:0] resp_src2_data;
    logic          dump_start;
    logic          dump_busy;
    logic          dump_valid;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          rf_csb0;
    logic          rf_werf;
    logic [AW-1:0] rf_src1_addr;
    logic [AW-1:0] rf_src2_addr;
    logic [AW-1:0] rf_tgt_addr;
    logic [DW-1:0] rf_tgt_data;
    logic [DW-1:0] rf_src1_data;
    logic [DW-1:0] rf_src2_data;

    modport master (
        input  req_valid, req_src1, req_src2, req_wen, req_tgt, req_wdata,
        input  dump_start, rf_src1_data, rf_src2_data,
        output req_ready, resp_valid, resp_src1_data, resp_src2_data,
        output dump_busy, dump_valid, dump_idx, dump_data,
        output rf_csb0, rf_werf, rf_src1_addr, rf_src2_addr, rf_tgt_addr, rf_tgt_data
    );

    modport slave (
        output req_valid, req_src1, req_src2, req_wen, req_tgt, req_wdata,
        output dump_start, rf_src1_data, rf_src2_data,
        input  req_ready, resp_valid, resp_src1_data, resp_src2_data,
        input  dump_busy, dump_valid, dump_idx, dump_data,
        input  rf_csb0, rf_werf, rf_src1_addr, rf_src2_addr, rf_tgt_addr, rf_tgt_data
    );
endinterface

// File: rtl/regfile_initiator.sv
// RiSC-16 register-file initiator: issues core reads/writes, hides the file's
// 1-cycle read latency and read-old-on-write behaviour, and sequences a debug dump.
module regfile_initiator #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                 clk0,
    input  logic                 rstb,
    regfile_initiator_if.master  bus
);
    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_DUMP  = 2'd1;
    localparam logic [1:0]    ST_DRAIN = 2'd2;
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          resp_valid_q, resp_valid_d;
    logic          byp1_q, byp1_d, byp2_q, byp2_d;
    logic          zero1_q, zero1_d, zero2_q, zero2_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] resp1_hold_q, resp1_hold_d, resp2_hold_q, resp2_hold_d;
    logic          dump_valid_q, dump_valid_d;
    logic [AW-1:0] dump_idx_q, dump_idx_d;
    logic [DW-1:0] dump_hold_q, dump_hold_d;

    logic          fire;
    logic          wr_ok;
    logic          in_dump;
    logic [DW-1:0] resp1_sel, resp2_sel, dump_sel;

    // rstb gates acceptance so nothing reaches the file while reset is held.
    assign bus.req_ready = rstb && (state_q == ST_IDLE) && !bus.dump_start;
    assign fire          = bus.req_valid && bus.req_ready;
    assign wr_ok         = bus.req_wen && (bus.req_tgt != '0);
    assign in_dump       = (state_q == ST_DUMP);

    assign bus.rf_csb0      = in_dump ? 1'b0 : !fire;
    assign bus.rf_werf      = !(fire && wr_ok);
    assign bus.rf_src1_addr = in_dump ? idx_q : bus.req_src1;
    assign bus.rf_src2_addr = in_dump ? '0 : bus.req_src2;
    assign bus.rf_tgt_addr  = bus.req_tgt;
    assign bus.rf_tgt_data  = bus.req_wdata;

    // The file returns the pre-write value on a same-cycle write, so forward the write data.
    assign resp1_sel = byp1_q ? wdata_q : (zero1_q ? '0 : bus.rf_src1_data);
    assign resp2_sel = byp2_q ? wdata_q : (zero2_q ? '0 : bus.rf_src2_data);
    assign dump_sel  = (dump_idx_q == '0) ? '0 : bus.rf_src1_data;

    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_src1_data = resp_valid_q ? resp1_sel : resp1_hold_q;
    assign bus.resp_src2_data = resp_valid_q ? resp2_sel : resp2_hold_q;
    assign bus.dump_busy      = (state_q != ST_IDLE);
    assign bus.dump_valid     = dump_valid_q;
    assign bus.dump_idx       = dump_idx_q;
    assign bus.dump_data      = dump_valid_q ? dump_sel : dump_hold_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.dump_start) begin
                    state_d = ST_DUMP;
                    idx_d   = '0;
                end
            end
            ST_DUMP: begin
                if (idx_q == IDX_LAST) state_d = ST_DRAIN;
                else                   idx_d   = idx_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resp_valid_d = fire;
        byp1_d       = byp1_q;
        byp2_d       = byp2_q;
        zero1_d      = zero1_q;
        zero2_d      = zero2_q;
        wdata_d      = wdata_q;
        if (fire) begin
            byp1_d  = wr_ok && (bus.req_src1 == bus.req_tgt);
            byp2_d  = wr_ok && (bus.req_src2 == bus.req_tgt);
            zero1_d = (bus.req_src1 == '0);
            zero2_d = (bus.req_src2 == '0);
            wdata_d = bus.req_wdata;
        end
        resp1_hold_d = bus.resp_src1_data;
        resp2_hold_d = bus.resp_src2_data;
        dump_valid_d = in_dump;
        dump_idx_d   = in_dump ? idx_q : dump_idx_q;
        dump_hold_d  = bus.dump_data;
    end

    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            resp_valid_q <= 1'b0;
            byp1_q       <= 1'b0;
            byp2_q       <= 1'b0;
            zero1_q      <= 1'b0;
            zero2_q      <= 1'b0;
            wdata_q      <= '0;
            resp1_hold_q <= '0;
            resp2_hold_q <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            resp_valid_q <= resp_valid_d;
            byp1_q       <= byp1_d;
            byp2_q       <= byp2_d;
            zero1_q      <= zero1_d;
            zero2_q      <= zero2_d;
            wdata_q      <= wdata_d;
            resp1_hold_q <= resp1_hold_d;
            resp2_hold_q <= resp2_hold_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_hold_q  <= dump_hold_d;
        end
    end
endmodule

// File: tb/tb_regfile_initiator.sv
// Bench for regfile_initiator: behavioural register file with registered,
// read-old-on-write reads, directed requests, and a queue-based response/dump scoreboard.
module tb_regfile_initiator;
    logic clk0 = 1'b0;
    logic rstb = 1'b0;

    regfile_initiator_if #(.DW(16), .AW(3)) bus ();

    regfile_initiator #(.DW(16), .AW(3)) dut (
        .clk0 (clk0),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk0 = ~clk0;

    // Register-file model; r0 and the others start with junk so forced zeros and bypasses show.
    logic [15:0] rf_mem [8] = '{16'hDEAD, 16'hA001, 16'hA002, 16'hA003,
                                16'hA004, 16'hA005, 16'hA006, 16'hA007};
    logic [15:0] rd1 = 16'h0000;
    logic [15:0] rd2 = 16'h0000;
    assign bus.rf_src1_data = rd1;
    assign bus.rf_src2_data = rd2;

    always @(posedge clk0) begin
        if (!bus.rf_csb0) begin
            if (!bus.rf_werf) rf_mem[bus.rf_tgt_addr] <= bus.rf_tgt_data;
            rd1 <= rf_mem[bus.rf_src1_addr];
            rd2 <= rf_mem[bus.rf_src2_addr];
        end
    end

    typedef struct { logic [15:0] d1; logic [15:0] d2; } resp_t;
    typedef struct { logic [2:0] idx; logic [15:0] data; } dump_t;
    resp_t resp_q [$];
    dump_t dump_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk0) begin
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                $display("resp: src1=%h src2=%h (want %h %h)",
                         bus.resp_src1_data, bus.resp_src2_data, e.d1, e.d2);
                chk("resp_src1", {16'h0, bus.resp_src1_data}, {16'h0, e.d1});
                chk("resp_src2", {16'h0, bus.resp_src2_data}, {16'h0, e.d2});
            end
        end
        if (bus.dump_valid) begin
            if (dump_q.size() == 0) begin
                chk("dump_unexpected", 32'd1, 32'd0);
            end else begin
                dump_t e;
                e = dump_q.pop_front();
                $display("dump: idx=%0d data=%h (want %0d %h)",
                         bus.dump_idx, bus.dump_data, e.idx, e.data);
                chk("dump_idx", {29'h0, bus.dump_idx}, {29'h0, e.idx});
                chk("dump_data", {16'h0, bus.dump_data}, {16'h0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    // Present one request for a single cycle; it must be accepted and issued.
    task automatic do_req(input logic [2:0] s1, input logic [2:0] s2, input logic w,
                          input logic [2:0] t, input logic [15:0] d,
                          input logic [15:0] e1, input logic [15:0] e2, input logic ew);
        resp_t r;
        bus.req_valid = 1'b1;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        bus.req_wen   = w;
        bus.req_tgt   = t;
        bus.req_wdata = d;
        #1;
        chk("req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rf_csb0_issue", {31'h0, bus.rf_csb0}, 32'd0);
        chk("rf_werf", {31'h0, bus.rf_werf}, {31'h0, ew});
        r.d1 = e1;
        r.d2 = e2;
        resp_q.push_back(r);
        tick();
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < 8; i++) begin
            dump_t e;
            e.idx  = 3'(i);
            e.data = (i == 0) ? 16'h0000 : 16'(16'h0011 * i);
            dump_q.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int k;
        int dv;
        bus.req_valid  = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.req_wen    = 1'b0;
        bus.req_tgt    = '0;
        bus.req_wdata  = '0;
        bus.dump_start = 1'b0;

        repeat (3) @(negedge clk0);
        chk("rst_csb0", {31'h0, bus.rf_csb0}, 32'd1);
        chk("rst_werf", {31'h0, bus.rf_werf}, 32'd1);
        tick();
        rstb = 1'b1;
        #1;
        chk("rel_csb0", {31'h0, bus.rf_csb0}, 32'd1);
        chk("rel_werf", {31'h0, bus.rf_werf}, 32'd1);
        chk("rel_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("rel_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rel_dump_busy", {31'h0, bus.dump_busy}, 32'd0);
        chk("rel_resp_data", {bus.resp_src1_data, bus.resp_src2_data}, 32'h0);
        tick();

        // Write r3, then read it back-to-back; r0 reads as zero despite the file holding junk.
        do_req(3'd0, 3'd0, 1'b1, 3'd3, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
        do_req(3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000, 1'b1);
        // Same-cycle write and read of r5 on both ports must bypass the stale 0xA005.
        do_req(3'd5, 3'd5, 1'b1, 3'd5, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        // A write to r0 is suppressed and r0 still reads zero.
        do_req(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        do_req(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        do_req(3'd5, 3'd3, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'hBEEF, 1'b1);
        tick();
        chk("hold_src1", {16'h0, bus.resp_src1_data}, 32'h1234);
        chk("hold_src2", {16'h0, bus.resp_src2_data}, 32'hBEEF);

        for (int i = 1; i < 8; i++)
            do_req(3'(i), 3'd0, 1'b1, 3'(i), 16'(16'h0011 * i), 16'(16'h0011 * i), 16'h0000, 1'b0);
        tick();

        // dump_start wins over a same-cycle request.
        bus.dump_start = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_src1   = 3'd1;
        #1;
        chk("dump_blocks_req", {31'h0, bus.req_ready}, 32'd0);
        push_dump();
        tick();
        bus.dump_start = 1'b0;
        bus.req_valid  = 1'b0;
        busy_cnt = 0;
        repeat (12) begin
            @(negedge clk0);
            if (bus.dump_busy) begin
                busy_cnt++;
                chk("ready_low_in_dump", {31'h0, bus.req_ready}, 32'd0);
            end
        end
        chk("dump_busy_cycles", busy_cnt, 32'd9);
        chk("ready_after_drain", {31'h0, bus.req_ready}, 32'd1);
        chk("dump_all_seen", dump_q.size(), 32'd0);
        tick();

        // Reset in the middle of a dump.
        bus.dump_start = 1'b1;
        push_dump();
        tick();
        bus.dump_start = 1'b0;
        k = 0;
        while (!(bus.dump_valid && bus.dump_idx == 3'd4) && k < 20) begin
            @(negedge clk0);
            k++;
        end
        chk("reach_idx4", {31'h0, k < 20}, 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        dump_q.delete();
        chk("mid_rst_dump_valid", {31'h0, bus.dump_valid}, 32'd0);
        chk("mid_rst_dump_busy", {31'h0, bus.dump_busy}, 32'd0);
        chk("mid_rst_dump_idx", {29'h0, bus.dump_idx}, 32'd0);
        chk("mid_rst_dump_data", {16'h0, bus.dump_data}, 32'd0);
        chk("mid_rst_csb0", {31'h0, bus.rf_csb0}, 32'd1);
        chk("mid_rst_werf", {31'h0, bus.rf_werf}, 32'd1);
        chk("mid_rst_resp", {31'h0, bus.resp_valid}, 32'd0);
        chk("mid_rst_resp_data", {bus.resp_src1_data, bus.resp_src2_data}, 32'h0);
        tick();
        tick();
        rstb = 1'b1;
        do_req(3'd3, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h0033, 16'h0055, 1'b1);
        dv = 0;
        repeat (12) begin
            @(negedge clk0);
            if (bus.dump_valid) dv++;
        end
        chk("no_dump_after_rst", dv, 32'd0);
        chk("resp_all_seen", resp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
